// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud-counter derivation,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit (integer division of clock rate by baud rate).
  function automatic int uart_cnt_baud_max(input int clk_f, input int baud);
    return clk_f / baud;
  endfunction

  function automatic int uart_cnt_half(input int clk_f, input int baud);
    return uart_cnt_baud_max(clk_f, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus one delay flop
// used to detect the synced high-to-low start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_p0;
  logic rx_p1;
  logic rx_p2;

  // Flops preset to idle-high so leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_sync = rx_p1;
  assign rx_fall = rx_p2 & ~rx_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling from a free baud counter.
// Optional macro UART_RX_FERR_EN: a zero stop bit raises po_ferr instead of po_flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_frequence = 5_000_000,
  parameter int baud_rate     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       po_ferr
);

  localparam int CNT_BAUD_MAX = uart_cnt_baud_max(clk_frequence, baud_rate);
  localparam int CNT_HALF     = uart_cnt_half(clk_frequence, baud_rate);
  localparam int CNT_W        = $clog2(CNT_BAUD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_BAUD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CNT_HALF - 1);

  uart_state_t      state;
  uart_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic             rx_sync;
  logic             rx_fall;
  logic             start_smp;
  logic             bit_smp;
  logic             stop_smp;
  logic [7:0]       shift_p0;
  logic             vld_p0;
  logic             flag_ok;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Falling edges only matter in IDLE; elsewhere the counter drives progress.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_fall) state_nxt = START;
      START:   if (start_smp) state_nxt = rx_sync ? IDLE : DATA;
      DATA:    if (bit_smp && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (stop_smp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_smp = (state == START) && (cnt == CNT_MID);
    bit_smp   = (state == DATA)  && (cnt == CNT_LAST);
    stop_smp  = (state == STOP)  && (cnt == CNT_LAST);
  end

  // Leaving STOP at mid-bit lets a start edge in the stop bit's second half open the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
    end else begin
      if ((state == IDLE) || start_smp || (cnt == CNT_LAST)) cnt <= '0;
      else                                                    cnt <= cnt + 1'b1;
      if (state != DATA) bit_cnt <= 3'd0;
      else if (bit_smp)  bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (bit_smp) shift_p0[bit_cnt] <= rx_sync;
  end

  // ---- stage p0: stop-bit sample captured ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= stop_smp;
  end

`ifdef UART_RX_FERR_EN
  logic stop_p0;

  always_ff @(posedge clk) begin
    if (stop_smp) stop_p0 <= rx_sync;
  end

  assign flag_ok = stop_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) po_ferr <= 1'b0;
    else        po_ferr <= vld_p0 & ~stop_p0;
  end
`else
  assign flag_ok = 1'b1;
  assign po_ferr = 1'b0;
`endif

  // ---- stage p1: byte presented ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_flag <= 1'b0;
      po_data <= 8'h00;
    end else begin
      po_flag <= vld_p0 & flag_ok;
      if (vld_p0 && flag_ok) po_data <= shift_p0;
    end
  end

endmodule
